button_debouncer: RTL and testbench

Conditions one raw Elbert V2 push-button (active-low, asynchronous, bouncing) into a clean, synchronous, active-high level plus single-cycle press/release pulses and a press-toggled latch. Sits directly upstream of the inverter/LED logic and drives its input in place of a free-running clock. One instance per button.

---
 rtl/button_debouncer.sv | 133 +++++++++++++
 tb/tb_button_debouncer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes a raw, bouncing pad signal and qualifies
// every change over STABLE_COUNT clock cycles. It produces a clean active-high
// level, single-cycle press/release pulses, and a latch that flips on each press.
module button_debouncer #(
    parameter int STABLE_COUNT = 12000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic clock,
    input  logic resetN,
    input  logic buttonIn,
    output logic level,
    output logic pressed,
    output logic released,
    output logic toggle
);

    localparam int        CW      = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_COUNT);
    // Pad level while the button is not touched; the synchronizer starts here so
    // leaving reset never looks like a press.
    localparam logic      PAD_IDLE = ACTIVE_LOW;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            pressed_q, pressed_d;
    logic            released_q, released_d;
    logic            toggle_q, toggle_d;
    logic            norm;

    // 1 means pressed, whatever the pad polarity is.
    assign norm = sync2_q ^ ACTIVE_LOW;

    // Two-flop synchronizer for the asynchronous pad.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= PAD_IDLE;
            sync2_q <= PAD_IDLE;
        end else begin
            sync1_q <= buttonIn;
            sync2_q <= sync1_q;
        end
    end

    // State, qualification counter and registered outputs.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= RELEASED;
            count_q    <= '0;
            level_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            toggle_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            toggle_q   <= toggle_d;
        end
    end

    // Next state. Any disagreement during a WAIT state drops straight back to the
    // stable state, so the qualification always restarts from zero.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        level_d    = level_q;
        toggle_d   = toggle_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (norm) begin
                    state_d = PRESS_WAIT;
                    count_d = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!norm) begin
                    state_d = RELEASED;
                    count_d = '0;
                end else if (count_q == CNT_DONE) begin
                    state_d   = PRESSED;
                    count_d   = '0;
                    level_d   = 1'b1;
                    pressed_d = 1'b1;
                    toggle_d  = ~toggle_q;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!norm) begin
                    state_d = RELEASE_WAIT;
                    count_d = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (norm) begin
                    state_d = PRESSED;
                    count_d = '0;
                end else if (count_q == CNT_DONE) begin
                    state_d    = RELEASED;
                    count_d    = '0;
                    level_d    = 1'b0;
                    released_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                count_d = '0;
            end
        endcase
    end

    assign level    = level_q;
    assign pressed  = pressed_q;
    assign released = released_q;
    assign toggle   = toggle_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an active-low instance runs the main scenarios,
// and an active-high instance checks the opposite polarity. Expected outputs are
// queued when the stimulus is driven. They are popped and compared after the
// clock edge.
module tb_button_debouncer;

    localparam int SC  = 4;
    localparam int LAT = SC + 2;

    logic clock, resetN, btn_l, btn_h;
    logic level_l, pressed_l, released_l, toggle_l;
    logic level_h, pressed_h, released_h, toggle_h;

    button_debouncer #(.STABLE_COUNT(SC), .ACTIVE_LOW(1'b1)) dut_l (
        .clock(clock), .resetN(resetN), .buttonIn(btn_l),
        .level(level_l), .pressed(pressed_l), .released(released_l), .toggle(toggle_l)
    );

    button_debouncer #(.STABLE_COUNT(SC), .ACTIVE_LOW(1'b0)) dut_h (
        .clock(clock), .resetN(resetN), .buttonIn(btn_h),
        .level(level_h), .pressed(pressed_h), .released(released_h), .toggle(toggle_h)
    );

    initial clock = 1'b0;
    always #1 clock = ~clock;

    // Expected output bits are ordered {level, pressed, released, toggle}.
    typedef struct {
        string      nm;
        logic       sel;
        logic [3:0] exp;
    } sb_t;

    typedef struct packed {
        logic       btn;
        logic [3:0] exp;
    } vec_t;

    sb_t sb_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_one();
        sb_t        e;
        logic [3:0] act;
        e   = sb_q.pop_front();
        act = e.sel ? {level_h, pressed_h, released_h, toggle_h}
                    : {level_l, pressed_l, released_l, toggle_l};
        n_chk++;
        if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got {lvl,prs,rel,tog}=%b expected %b",
                     e.nm, cyc, act, e.exp);
        end
    endtask

    // Called at a falling edge. The input is driven here, the rising edge
    // follows, and the compare happens at the next falling edge.
    task automatic step(input string nm, input logic sel, input logic btn, input logic [3:0] exp);
        if (sel) btn_h = btn;
        else     btn_l = btn;
        sb_q.push_back('{nm, sel, exp});
        @(negedge clock);
        check_one();
    endtask

    // Hold a new pad value for n edges (edge 0 being the first). The level flips
    // and a pulse fires on edge LAT.
    task automatic qualify(input string nm, input logic sel, input logic btn, input logic new_lvl,
                           input logic tog_before, input logic tog_after, input int n);
        logic [3:0] e;
        for (int k = 0; k < n; k++) begin
            e[3] = (k >= LAT) ? new_lvl : ~new_lvl;
            e[2] = (k == LAT) && new_lvl;
            e[1] = (k == LAT) && !new_lvl;
            e[0] = (k >= LAT) ? tog_after : tog_before;
            step(nm, sel, btn, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit hit, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t press_tab[9];
        logic bounce[10];

        press_tab[0] = {1'b0, 4'b0000};
        press_tab[1] = {1'b0, 4'b0000};
        press_tab[2] = {1'b0, 4'b0000};
        press_tab[3] = {1'b0, 4'b0000};
        press_tab[4] = {1'b0, 4'b0000};
        press_tab[5] = {1'b0, 4'b0000};
        press_tab[6] = {1'b0, 4'b1101};
        press_tab[7] = {1'b0, 4'b1001};
        press_tab[8] = {1'b0, 4'b1001};

        bounce = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        resetN = 1'b0;
        btn_l  = 1'b1;
        btn_h  = 1'b0;
        @(negedge clock);

        // Reset state, then 20 quiet cycles after release.
        for (int k = 0; k < 3; k++) step("rst_hold", 1'b0, 1'b1, 4'b0000);
        step("rst_hold_h", 1'b1, 1'b0, 4'b0000);
        resetN = 1'b1;
        for (int k = 0; k < 20; k++) step("idle", 1'b0, 1'b1, 4'b0000);

        // Clean press, taken from the vector table.
        for (int k = 0; k < 9; k++) step("press1", 1'b0, press_tab[k].btn, press_tab[k].exp);

        // Clean release, then a second press that brings toggle back to 0.
        qualify("release1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9);
        qualify("press2",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9);
        qualify("release2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9);

        // Bounce: low 3, high 1, low 2, then high. Nothing may change.
        for (int k = 0; k < 10; k++) step("bounce", 1'b0, bounce[k], 4'b0000);
        qualify("bounce_press", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9);
        qualify("release3",     1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9);

        // Reset during press qualification (after edge 3), button still held.
        for (int k = 0; k < 4; k++) step("pre_rst", 1'b0, 1'b0, 4'b0001);
        resetN = 1'b0;
        for (int k = 0; k < 2; k++) step("mid_rst", 1'b0, 1'b0, 4'b0000);
        resetN = 1'b1;
        qualify("rst_press", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9);

        // Active-high polarity instance.
        qualify("pol_press", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9);

        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
